// File: rtl/rr_gnt_dispatch20.sv
// Round-robin grant dispatcher: captures the granted port's descriptor into a small FWFT FIFO
// and returns an arbitration credit. Optional sticky error detection via macro RR_DISP_ERR_EN.
module rr_gnt_dispatch20 #(
    parameter int NUM_OF_INPUT = 20,
    parameter int INPUT_NBITS  = 5,
    parameter int DATA_NBITS   = 32,
    parameter int DEPTH        = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               gnt,
    input  logic [INPUT_NBITS-1:0]             sel,
    input  logic [NUM_OF_INPUT-1:0]            in_valid,
    input  logic [NUM_OF_INPUT*DATA_NBITS-1:0] in_data,
    output logic                               en,
    output logic [NUM_OF_INPUT-1:0]            pop,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_NBITS-1:0]              out_data,
    output logic [INPUT_NBITS-1:0]             out_port,
    output logic                               err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = INPUT_NBITS + DATA_NBITS;

    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]  mem_q [DEPTH];
    logic [EW-1:0]  mem_d [DEPTH];

    logic                  sel_hit;
    logic                  sel_valid;
    logic [DATA_NBITS-1:0] sel_data;
    logic                  accept;
    logic                  empty;
    logic                  full;
    logic                  retire;
    logic                  wr;
    logic [EW-1:0]         head;
    logic [CW:0]           credit_sum;

    // Decoding by loop keeps an out-of-range sel from ever indexing past in_valid/in_data.
    always_comb begin
        sel_hit   = 1'b0;
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_OF_INPUT; i++) begin
            if (sel == INPUT_NBITS'(i)) begin
                sel_hit   = 1'b1;
                sel_valid = in_valid[i];
                sel_data  = in_data[i*DATA_NBITS +: DATA_NBITS];
            end
        end
    end

    assign accept = gnt & sel_hit & sel_valid & ~rst;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_OF_INPUT; i++) begin
            pop[i] = accept & (sel == INPUT_NBITS'(i));
        end
    end

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign out_valid = ~rst & ~empty;
    assign retire    = out_valid & out_ready;
    assign wr        = accept & (~full | retire);

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (wr && !retire) begin
            count_d = count_q + CW'(1);
        end else if (retire && !wr) begin
            count_d = count_q - CW'(1);
        end
        if (wr) begin
            wr_ptr_d        = wr_ptr_q + PW'(1);
            mem_d[wr_ptr_q] = {sel, sel_data};
        end
        if (retire) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is only visible while count is non-zero.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head     = mem_q[rd_ptr_q];
    assign out_data = out_valid ? head[DATA_NBITS-1:0] : '0;
    assign out_port = out_valid ? head[EW-1 -: INPUT_NBITS] : '0;

    // Credit leaves room for a grant that arrives one cycle after en.
    assign credit_sum = {1'b0, count_q} + {{CW{1'b0}}, gnt};
    assign en         = ~rst & (credit_sum <= (CW+1)'(DEPTH - 1));

`ifdef RR_DISP_ERR_EN
    logic err_q, err_d;
    logic drop_grant;
    logic overflow;

    assign drop_grant = gnt & ~rst & ~(sel_hit & sel_valid);
    assign overflow   = accept & full & ~retire;

    always_comb begin
        err_d = err_q | drop_grant | overflow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q & ~rst;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rr_gnt_dispatch20.sv
// Scoreboard bench for rr_gnt_dispatch20: directed grants push expected entries, a negedge
// monitor pops and compares every accepted output beat.
module tb_rr_gnt_dispatch20;

    localparam int N  = 20;
    localparam int IB = 5;
    localparam int DB = 32;
    localparam int D  = 4;

`ifdef RR_DISP_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            gnt;
    logic [IB-1:0]   sel;
    logic [N-1:0]    in_valid;
    logic [N*DB-1:0] in_data;
    logic            en;
    logic [N-1:0]    pop;
    logic            out_valid;
    logic            out_ready;
    logic [DB-1:0]   out_data;
    logic [IB-1:0]   out_port;
    logic            err;

    int errors = 0;
    int checks = 0;
    logic [IB+DB-1:0] exp_q [$];
    logic [IB+DB-1:0] mon_e;
    logic exp_err = 1'b0;

    rr_gnt_dispatch20 #(
        .NUM_OF_INPUT(N), .INPUT_NBITS(IB), .DATA_NBITS(DB), .DEPTH(D)
    ) dut (
        .clk(clk), .rst(rst), .gnt(gnt), .sel(sel), .in_valid(in_valid), .in_data(in_data),
        .en(en), .pop(pop), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_port(out_port), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] oh(input int p);
        return 64'd1 << p;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Drive a valid grant for port p; caller has already advanced to the cycle.
    task automatic drive_grant(input int p, input logic [31:0] d, input bit exp_wr);
        in_valid          = '0;
        in_valid[p]       = 1'b1;
        in_data[p*DB +: DB] = d;
        gnt               = 1'b1;
        sel               = IB'(p);
        #1;
        chk("pop_onehot", 64'(pop), oh(p));
        if (exp_wr) exp_q.push_back({IB'(p), d});
    endtask

    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: actual port=%0d data=%0h required=none",
                         out_port, out_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("mon_port", 64'(out_port), 64'(mon_e[IB+DB-1:DB]));
                chk("mon_data", 64'(out_data), 64'(mon_e[DB-1:0]));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wrap_ports [10] = '{19, 0, 1, 2, 3, 4, 5, 6, 7, 8};
        int issued;
        bit prev_en;

        // Reset state, with a grant presented that must be ignored
        rst = 1'b1; gnt = 1'b1; sel = IB'(3); in_valid = '0; in_valid[3] = 1'b1;
        in_data = '0; out_ready = 1'b1;
        repeat (2) next_cycle();
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_port",  64'(out_port),  64'd0);
        chk("rst_err",       64'(err),       64'd0);
        chk("rst_en",        64'(en),        64'd0);
        chk("rst_pop",       64'(pop),       64'd0);
        next_cycle();
        rst = 1'b0; gnt = 1'b0; in_valid = '0;
        #1;
        chk("post_rst_en", 64'(en), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Single grant, latency one
        next_cycle();
        drive_grant(7, 32'hDEADBEEF, 1'b1);
        next_cycle();
        gnt = 1'b0; in_valid = '0;
        #1;
        chk("single_out_valid", 64'(out_valid), 64'd1);
        chk("single_out_data",  64'(out_data),  64'hDEADBEEF);
        chk("single_out_port",  64'(out_port),  64'd7);
        next_cycle();
        chk("single_drained", 64'(out_valid), 64'd0);

        // Backpressure, credit and overflow
        for (int p = 0; p < 3; p++) begin
            next_cycle();
            out_ready = 1'b0;
            drive_grant(p, 32'h1000_0000 + p, 1'b1);
            chk("bp_en_fill", 64'(en), 64'd1);
        end
        next_cycle();
        gnt = 1'b0; in_valid = '0;
        #1;
        chk("bp_cnt3_en", 64'(en), 64'd1);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_port", 64'(out_port), 64'd0);
        next_cycle();
        drive_grant(3, 32'h1000_0003, 1'b1);
        chk("bp_cnt3_gnt_en", 64'(en), 64'd0);
        next_cycle();
        gnt = 1'b0; in_valid = '0;
        #1;
        chk("bp_full_en", 64'(en), 64'd0);
        chk("bp_hold_data", 64'(out_data), 64'h1000_0000);
        next_cycle();
        drive_grant(4, 32'h1000_0004, 1'b0);
        exp_err = ERR_ON;
        next_cycle();
        gnt = 1'b0; in_valid = '0; out_ready = 1'b1;
        #1;
        chk("overflow_err", 64'(err), 64'(exp_err));
        chk("overflow_en", 64'(en), 64'd0);
        repeat (4) next_cycle();
        #1;
        chk("bp_drained_valid", 64'(out_valid), 64'd0);
        chk("bp_drained_queue", 64'(exp_q.size()), 64'd0);

        // Pointer wrap with out_ready every other cycle, grants gated by previous-cycle en
        issued = 0;
        prev_en = 1'b1;
        for (int c = 0; c < 60 && issued < 10; c++) begin
            next_cycle();
            out_ready = c[0];
            if (prev_en) begin
                drive_grant(wrap_ports[issued], 32'hA000_0000 + wrap_ports[issued], 1'b1);
                issued++;
            end else begin
                gnt = 1'b0; in_valid = '0;
                #1;
            end
            prev_en = en;
        end
        chk("wrap_issued", 64'(issued), 64'd10);
        next_cycle();
        gnt = 1'b0; in_valid = '0; out_ready = 1'b1;
        repeat (6) next_cycle();
        #1;
        chk("wrap_drained_queue", 64'(exp_q.size()), 64'd0);
        chk("wrap_drained_valid", 64'(out_valid), 64'd0);

        // Simultaneous write and retire at DEPTH-1
        for (int p = 9; p < 12; p++) begin
            next_cycle();
            out_ready = 1'b0;
            drive_grant(p, 32'hC000_0000 + p, 1'b1);
        end
        next_cycle();
        out_ready = 1'b1;
        drive_grant(12, 32'hC000_000C, 1'b1);
        chk("sim_en", 64'(en), 64'd0);
        next_cycle();
        gnt = 1'b0; in_valid = '0; out_ready = 1'b0;
        #1;
        chk("sim_cnt_en", 64'(en), 64'd1);
        chk("sim_head_port", 64'(out_port), 64'd10);
        next_cycle();
        out_ready = 1'b1;
        next_cycle();
        next_cycle();
        chk("sim_tail_port", 64'(out_port), 64'd12);
        next_cycle();
        chk("sim_drained_valid", 64'(out_valid), 64'd0);

        // Mid-operation reset discards buffered entries
        for (int p = 13; p < 16; p++) begin
            next_cycle();
            out_ready = 1'b0;
            drive_grant(p, 32'hE000_0000 + p, 1'b1);
        end
        next_cycle();
        gnt = 1'b0; in_valid = '0; rst = 1'b1;
        exp_q.delete();
        exp_err = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_err", 64'(err), 64'd0);
        chk("midrst_en", 64'(en), 64'd0);
        next_cycle();
        rst = 1'b0;
        #1;
        chk("midrst_after_en", 64'(en), 64'd1);
        chk("midrst_after_valid", 64'(out_valid), 64'd0);
        next_cycle();
        out_ready = 1'b1;
        #1;
        chk("midrst_empty", 64'(out_valid), 64'd0);

        // Bad grants: invalid port, out-of-range index
        next_cycle();
        in_valid = '1; in_valid[5] = 1'b0; gnt = 1'b1; sel = IB'(5);
        #1;
        chk("bad_invalid_pop", 64'(pop), 64'd0);
        next_cycle();
        in_valid = '1; gnt = 1'b1; sel = IB'(25);
        #1;
        chk("bad_range_pop", 64'(pop), 64'd0);
        next_cycle();
        gnt = 1'b0; in_valid = '0;
        exp_err = ERR_ON;
        #1;
        chk("bad_no_write", 64'(out_valid), 64'd0);
        chk("bad_err", 64'(err), 64'(exp_err));
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
